// File: rtl/dram_dump_tx.sv
// Reads count bytes from DRAM starting at base_addr and sends them as 8N1 UART frames on tx.
// Latency: the first start bit goes out 2 cycles after start is accepted; each frame is 10*CLKS_PER_BIT cycles, with 2 idle-high cycles between frames.
// Backpressure: none; start is accepted only in IDLE while not busy, and input changes while busy are ignored.
//
// Ports:
//   clk, rst        - single clock; asynchronous active-low reset
//   start           - dump request; base_addr/count are latched when it is accepted
//   base_addr/count - first DRAM address and byte count
//   mem_addr/mem_q  - registered DRAM read address; read data is sampled 2 edges later
//   busy/done       - busy spans start acceptance through the done pulse
//   tx              - registered UART line, idle high, LSB first
module dram_dump_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] count,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_q,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP, FIN} state_t;

  state_t        state;
  logic [7:0]    base_r;
  logic [7:0]    count_r;
  logic [7:0]    shreg;
  logic [8:0]    index;      // 9 bits so that index can reach 255 and still compare against count
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;

  logic [8:0]    index_nxt;
  logic          bit_end;

  assign index_nxt = index + 9'd1;
  assign bit_end   = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base_r   <= 8'h00;
      count_r  <= 8'h00;
      shreg    <= 8'h00;
      index    <= 9'd0;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      mem_addr <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // busy is still high in the cycle carrying done; clear it here and
          // only accept a new request once it has dropped.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            base_r   <= base_addr;
            count_r  <= count;
            index    <= 9'd0;
            busy     <= 1'b1;
            // Address is set on entry to FETCH so the data is ready at the end of WAIT.
            mem_addr <= base_addr;
            state    <= (count == 8'h00) ? FIN : FETCH;
          end
        end

        FETCH: state <= WAIT;

        WAIT: begin
          shreg   <= mem_q;
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= START;
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            index   <= index_nxt;
            if (index_nxt < {1'b0, count_r}) begin
              mem_addr <= base_r + index_nxt[7:0];
              state    <= FETCH;
            end else begin
              state <= FIN;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_dump_tx.sv
// Directed bench for dram_dump_tx with CLKS_PER_BIT=4: a UART frame decoder,
// a one-stage registered DRAM model and hand-computed expected bytes.
module tb_dram_dump_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] count;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic       busy;
  logic       done;
  logic       tx;

  dram_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .busy      (busy),
    .done      (done),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: read data settles one edge after the address, sampled by the DUT on the second.
  logic [7:0] dram [256];
  initial mem_q = 8'h00;
  always @(posedge clk) mem_q <= dram[mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame decoder, sampling on the falling edge.
  int         cyc = 0;
  int         pos = 0;
  bit         in_frame = 1'b0;
  int         shape_bad = 0;
  int         done_cnt = 0;
  logic       samp [FL];
  logic [9:0] last_pat = 10'h0;
  logic [7:0] rx_q [$];
  int         start_q [$];
  logic [7:0] addr_q [$];
  logic [7:0] last_addr = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (mem_addr !== last_addr) begin
      addr_q.push_back(mem_addr);
      last_addr = mem_addr;
    end
    if (rst !== 1'b1) begin
      in_frame = 1'b0;
    end else if (in_frame) begin
      samp[pos] = tx;
      pos = pos + 1;
      if (pos == FL) begin
        in_frame = 1'b0;
        for (int b = 0; b < 10; b++) begin
          last_pat[b] = samp[b*CPB];
          for (int k = 1; k < CPB; k++)
            if (samp[b*CPB+k] !== samp[b*CPB]) shape_bad++;
        end
        if (last_pat[0] !== 1'b0 || last_pat[9] !== 1'b1) shape_bad++;
        rx_q.push_back(last_pat[8:1]);
      end
    end else if (tx === 1'b0) begin
      in_frame = 1'b1;
      samp[0] = tx;
      pos = 1;
      start_q.push_back(cyc);
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(done_cnt != d0), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input int i, input int exp);
    int v;
    if (i < rx_q.size()) v = int'(rx_q[i]);
    else v = -1;
    check(tag, v, exp);
  endtask

  task automatic clear_q();
    rx_q.delete();
    start_q.delete();
    addr_q.delete();
  endtask

  int d0;
  int mism;
  int v;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    base_addr = 8'h00;
    count = 8'h00;
    for (int i = 0; i < 256; i++) dram[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 from 0x10
    dram[8'h10] = 8'hA5;
    clear_q();
    d0 = done_cnt;
    do_start(8'h10, 8'd1);
    wait_done("s1_done_seen", d0, 200);
    check("s1_nbytes", rx_q.size(), 1);
    check_rx("s1_byte", 0, 8'hA5);
    check("s1_tx_pattern", int'(last_pat), 10'h34A);
    check("s1_done_count", done_cnt - d0, 1);
    check("s1_busy_after", int'(busy), 0);

    // Address wrap FE, FF, 00 and inter-frame gap
    dram[8'hFE] = 8'h11;
    dram[8'hFF] = 8'h22;
    dram[8'h00] = 8'h33;
    clear_q();
    d0 = done_cnt;
    do_start(8'hFE, 8'd3);
    wait_done("s2_done_seen", d0, 400);
    check("s2_naddr", addr_q.size(), 3);
    if (addr_q.size() >= 3) begin
      check("s2_addr0", int'(addr_q[0]), 8'hFE);
      check("s2_addr1", int'(addr_q[1]), 8'hFF);
      check("s2_addr2", int'(addr_q[2]), 8'h00);
    end
    check("s2_nbytes", rx_q.size(), 3);
    check_rx("s2_byte0", 0, 8'h11);
    check_rx("s2_byte1", 1, 8'h22);
    check_rx("s2_byte2", 2, 8'h33);
    if (start_q.size() >= 3) begin
      check("s2_gap01", start_q[1] - start_q[0] - FL, 2);
      check("s2_gap12", start_q[2] - start_q[1] - FL, 2);
    end else begin
      check("s2_nstarts", start_q.size(), 3);
    end
    check("s2_done_count", done_cnt - d0, 1);

    // count = 0: no frame, done two cycles after start
    clear_q();
    d0 = done_cnt;
    do_start(8'h40, 8'd0);
    check("s3_busy_c1", int'(busy), 1);
    check("s3_done_c1", int'(done), 0);
    @(negedge clk);
    check("s3_busy_c2", int'(busy), 1);
    check("s3_done_c2", int'(done), 1);
    @(negedge clk);
    check("s3_busy_c3", int'(busy), 0);
    check("s3_done_c3", int'(done), 0);
    repeat (20) @(negedge clk);
    check("s3_no_start_bit", start_q.size(), 0);
    check("s3_done_count", done_cnt - d0, 1);

    // start re-pulsed with different parameters while busy
    dram[8'h20] = 8'h5A;
    dram[8'h21] = 8'hC3;
    for (int i = 8'h30; i < 8'h38; i++) dram[i] = 8'hEE;
    clear_q();
    d0 = done_cnt;
    do_start(8'h20, 8'd2);
    repeat (30) @(negedge clk);
    start = 1'b1;
    base_addr = 8'h30;
    count = 8'd5;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    base_addr = 8'h31;
    count = 8'd7;
    wait_done("s4_done_seen", d0, 400);
    repeat (60) @(negedge clk);
    check("s4_nbytes", rx_q.size(), 2);
    check_rx("s4_byte0", 0, 8'h5A);
    check_rx("s4_byte1", 1, 8'hC3);
    check("s4_done_count", done_cnt - d0, 1);

    // Reset during DATA bit 3 of 0x96 (bit 3 is a 0)
    dram[8'h40] = 8'h96;
    clear_q();
    d0 = done_cnt;
    do_start(8'h40, 8'd1);
    repeat (19) @(negedge clk);
    check("s5_tx_bit3_low", int'(tx), 0);
    #1 rst = 1'b0;
    #1;
    check("s5_async_tx", int'(tx), 1);
    check("s5_async_busy", int'(busy), 0);
    check("s5_async_mem_addr", int'(mem_addr), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    base_addr = 8'h40;
    count = 8'd1;
    @(posedge clk);
    #1;
    check("s5_first_edge_accept", int'(busy), 1);
    start = 1'b0;
    check("s5_no_done_after_abort", done_cnt - d0, 0);
    wait_done("s5_done_seen", d0, 200);
    check("s5_nbytes", rx_q.size(), 1);
    check_rx("s5_byte", 0, 8'h96);
    check("s5_done_count", done_cnt - d0, 1);

    // count = 255 from 0x00: addresses 0x00..0xFE
    for (int i = 0; i < 256; i++) dram[i] = 8'(i) ^ 8'h5C;
    clear_q();
    d0 = done_cnt;
    do_start(8'h00, 8'd255);
    wait_done("s6_done_seen", d0, 12000);
    repeat (60) @(negedge clk);
    check("s6_nframes", rx_q.size(), 255);
    mism = 0;
    for (int i = 0; i < 255; i++) begin
      if (i < rx_q.size()) v = int'(rx_q[i]);
      else v = -1;
      if (v != int'(8'(i) ^ 8'h5C)) mism++;
    end
    check("s6_byte_mismatches", mism, 0);
    check("s6_done_count", done_cnt - d0, 1);
    check("s6_busy_after", int'(busy), 0);

    check("frame_shape_errors", shape_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_dump_tx.md
DRAM_DUMP_TX -- requirements
Module: dram_dump_tx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 434; it is the clk cycles per UART bit (50 MHz / 115200).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: request a dump; sampled only in IDLE.
REQ-006 Port base_addr, input, 8 bits: first DRAM address; latched when start is accepted.
REQ-007 Port count, input, 8 bits: number of bytes to send; latched when start is accepted.
REQ-008 Port mem_addr, output, 8 bits: registered DRAM read address.
REQ-009 Port mem_q, input, 8 bits: DRAM read data, valid 2 rising edges after mem_addr changes.
REQ-010 Port busy, output, 1 bit: high from start acceptance until the done pulse, inclusive.
REQ-011 Port done, output, 1 bit: one-cycle pulse when the dump completes.
REQ-012 Port tx, output, 1 bit: UART serial line, 8N1, LSB first, idle high.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, WAIT, START, DATA, STOP and FIN.
REQ-014 IDLE with start=1 SHALL latch base_addr and count, then go to FIN if count=0 or to FETCH otherwise; busy rises on the same edge.
REQ-015 FETCH SHALL drive mem_addr = base_addr + index (mod 256, wrapping 0xFF->0x00); index starts at 0.
REQ-016 FETCH SHALL last one cycle and WAIT one cycle; at the end of WAIT, mem_q is captured into the shift register and the FSM goes to START.
REQ-017 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-018 DATA SHALL drive shift-register bit 0 for CLKS_PER_BIT cycles per bit, shifting right, for 8 bits.
REQ-019 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then increment index.
REQ-020 After STOP, the FSM SHALL go to FETCH if index < count, else to FIN.
REQ-021 FIN SHALL assert done for one cycle, drop busy on the next edge and return to IDLE.
REQ-022 Back-to-back frames SHALL have exactly 2 idle-high cycles (FETCH+WAIT) between the end of a stop bit and the next start bit.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 The bit-time counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide; the index counter SHALL be 9 bits so count=255 terminates correctly.
REQ-025 start while busy SHALL be ignored, with no effect on the latched parameters.
REQ-026 Changes on base_addr or count while busy SHALL have no effect.
REQ-027 tx SHALL be registered (glitch-free) and SHALL be 1 in every state except START and the 0-bits of DATA.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, tx=1, busy=0, done=0, mem_addr=0x00, index=0, bit counter=0, shift register=0x00.
REQ-029 Reset asserted mid-frame SHALL abort the transfer without completing the frame, and no done pulse SHALL follow.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-031 Scenario: CLKS_PER_BIT=4, DRAM[0x10]=0xA5, start with base=0x10, count=1 -> tx shows 0,1,0,1,0,0,1,0,1,1 (each held 4 cycles); done pulses once; busy low after.
REQ-032 Scenario: base=0xFE, count=3, DRAM[FE,FF,00]=11,22,33 -> mem_addr sequence FE,FF,00; bytes 0x11,0x22,0x33 sent in order; exactly 2 idle cycles between frames.
REQ-033 Scenario: count=0 -> no start bit ever appears on tx; done pulses 2 cycles after start; busy high for those 2 cycles.
REQ-034 Scenario: start re-pulsed with a different base mid-frame -> output bytes unchanged; one done only.
REQ-035 Scenario: rst=0 during DATA bit 3 -> tx=1 and busy=0 asynchronously; no done; a fresh start then sends a full correct frame.
REQ-036 Scenario: count=255, base=0x00 -> 255 frames from addresses 0x00..0xFE, then done; frame count checked by the scoreboard.
